// File: rtl/dadda_12_arbiter.sv
// Round-robin arbiter sharing one combinational dadda_12 multiplier between NUM_REQ
// requesters, with registered operands and a registered, held-until-accepted result.

// Combinational 12x12 Dadda-tree multiplier; product truncated to 23 bits.
module dadda_12 (
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [22:0] mul_result
);
  localparam int unsigned W    = 12;
  localparam int unsigned COLS = 2 * W;
  localparam int unsigned CIW  = $clog2(COLS);
  localparam int unsigned NSTG = 5;

  // Dadda height sequence for a 12-high partial-product matrix
  function automatic int stage_target(input int st);
    case (st)
      0:       return 9;
      1:       return 6;
      2:       return 4;
      3:       return 3;
      default: return 2;
    endcase
  endfunction

  logic [COLS-1:0] sum_row;
  logic [COLS-1:0] carry_row;

  // Columns are kept as bit queues: consumed from the LSB, appended above the current height
  always_comb begin
    logic [W-1:0] col  [COLS];
    logic [W-1:0] nxt  [COLS];
    int           hgt  [COLS];
    int           nhgt [COLS];
    int           tgt;
    int           total;
    logic         s;
    logic         co;

    tgt       = 0;
    total     = 0;
    s         = 1'b0;
    co        = 1'b0;
    sum_row   = '0;
    carry_row = '0;
    for (int c = 0; c < COLS; c++) begin
      col[CIW'(c)]  = '0;
      nxt[CIW'(c)]  = '0;
      hgt[CIW'(c)]  = 0;
      nhgt[CIW'(c)] = 0;
    end

    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        col[CIW'(i + j)] = col[CIW'(i + j)] | (W'(a[j] & b[i]) << hgt[CIW'(i + j)]);
        hgt[CIW'(i + j)] = hgt[CIW'(i + j)] + 1;
      end
    end

    for (int st = 0; st < NSTG; st++) begin
      tgt = stage_target(st);
      for (int c = 0; c < COLS; c++) begin
        nxt[CIW'(c)]  = '0;
        nhgt[CIW'(c)] = 0;
      end
      for (int c = 0; c < COLS; c++) begin
        // carries already placed in nxt count toward this column's height
        total = hgt[CIW'(c)] + nhgt[CIW'(c)];
        for (int k = 0; k < W / 2; k++) begin
          if (total > tgt && hgt[CIW'(c)] >= 2) begin
            if (total - tgt >= 2 && hgt[CIW'(c)] >= 3) begin
              s  = col[CIW'(c)][0] ^ col[CIW'(c)][1] ^ col[CIW'(c)][2];
              co = (col[CIW'(c)][0] & col[CIW'(c)][1]) |
                   (col[CIW'(c)][2] & (col[CIW'(c)][0] ^ col[CIW'(c)][1]));
              col[CIW'(c)] = col[CIW'(c)] >> 3;
              hgt[CIW'(c)] = hgt[CIW'(c)] - 3;
              total        = total - 2;
            end else begin
              s  = col[CIW'(c)][0] ^ col[CIW'(c)][1];
              co = col[CIW'(c)][0] & col[CIW'(c)][1];
              col[CIW'(c)] = col[CIW'(c)] >> 2;
              hgt[CIW'(c)] = hgt[CIW'(c)] - 2;
              total        = total - 1;
            end
            nxt[CIW'(c)]  = nxt[CIW'(c)] | (W'(s) << nhgt[CIW'(c)]);
            nhgt[CIW'(c)] = nhgt[CIW'(c)] + 1;
            if (c < COLS - 1) begin
              nxt[CIW'(c + 1)]  = nxt[CIW'(c + 1)] | (W'(co) << nhgt[CIW'(c + 1)]);
              nhgt[CIW'(c + 1)] = nhgt[CIW'(c + 1)] + 1;
            end
          end
        end
        nxt[CIW'(c)]  = nxt[CIW'(c)] | (col[CIW'(c)] << nhgt[CIW'(c)]);
        nhgt[CIW'(c)] = nhgt[CIW'(c)] + hgt[CIW'(c)];
      end
      for (int c = 0; c < COLS; c++) begin
        col[CIW'(c)] = nxt[CIW'(c)];
        hgt[CIW'(c)] = nhgt[CIW'(c)];
      end
    end

    for (int c = 0; c < COLS; c++) begin
      sum_row   = sum_row   | (COLS'(col[CIW'(c)][0]) << c);
      carry_row = carry_row | (COLS'(col[CIW'(c)][1]) << c);
    end
  end

  assign mul_result = 23'(sum_row + carry_row);
endmodule

module dadda_12_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*12-1:0] req_a,
  input  logic [NUM_REQ*12-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [22:0]           rsp_result,
  output logic                  busy
);
  localparam int unsigned OP_W  = 12;
  localparam int unsigned RES_W = 23;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic [OP_W-1:0]  a_r;
  logic [OP_W-1:0]  b_r;
  logic [ID_W-1:0]  id_r;
  logic [RES_W-1:0] mul_result;
  logic             grant_any;
  logic [ID_W-1:0]  grant_idx;
  logic [OP_W-1:0]  sel_a;
  logic [OP_W-1:0]  sel_b;
  logic             accept;

  dadda_12 u_mul (
    .a          (a_r),
    .b          (b_r),
    .mul_result (mul_result)
  );

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_any && req_valid[ID_W'(idx)]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[OP_W*i +: OP_W];
        sel_b = req_b[OP_W*i +: OP_W];
      end
    end
  end

  // Next state, accept strobe and the combinational grant
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (!rst && grant_any) begin
          req_ready = NUM_REQ'(1) << grant_idx;
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      a_r        <= '0;
      b_r        <= '0;
      id_r       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else begin
      if (accept) begin
        a_r  <= sel_a;
        b_r  <= sel_b;
        id_r <= grant_idx;
      end
      if (state == CALC) begin
        rsp_result <= mul_result;
        rsp_id     <= id_r;
        rsp_valid  <= 1'b1;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rr_ptr    <= (id_r == ID_W'(NUM_REQ - 1)) ? '0 : id_r + ID_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_dadda_12_arbiter.sv
// Bench for dadda_12_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dadda_12_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic            clk       = 1'b0;
  logic            rst       = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*12-1:0] req_a     = '0;
  logic [N*12-1:0] req_b     = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [IDW-1:0]  rsp_id;
  logic [22:0]     rsp_result;
  logic            busy;

  int tests = 0;
  int fails = 0;

  dadda_12_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Model: one operation in flight, its product, and whose turn it is next
  bit           m_busy  = 1'b0;
  bit           m_calc  = 1'b0;
  bit           m_rv    = 1'b0;
  int           m_rr    = 0;
  int           m_owner = 0;
  bit [22:0]    m_prod  = '0;
  bit [22:0]    m_res   = '0;
  bit [IDW-1:0] m_id    = '0;
  bit [N-1:0]   m_acc   = '0;

  function automatic int grant_of(input logic [N-1:0] v, input int rr);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (rr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [22:0] prod(input logic [11:0] a, input logic [11:0] b);
    return 23'(int'(a) * int'(b));
  endfunction

  function automatic logic [11:0] opnd(input logic [N*12-1:0] v, input int p);
    return 12'(v >> (12 * p));
  endfunction

  function automatic logic [11:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 12'd0;
      1:       return 12'hFFF;
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(input int p, input logic [11:0] a, input logic [11:0] b);
    req_valid[p]      = 1'b1;
    req_a[12*p +: 12] = a;
    req_b[12*p +: 12] = b;
  endtask

  always @(posedge clk or posedge rst) begin
    int g;
    if (rst) begin
      m_busy = 1'b0; m_calc = 1'b0; m_rv = 1'b0; m_rr = 0; m_owner = 0;
      m_prod = '0; m_res = '0; m_id = '0; m_acc = '0;
    end else begin
      m_acc = '0;
      if (!m_busy) begin
        g = grant_of(req_valid, m_rr);
        if (g >= 0) begin
          m_busy  = 1'b1;
          m_calc  = 1'b1;
          m_owner = g;
          m_prod  = prod(opnd(req_a, g), opnd(req_b, g));
          m_acc[g] = 1'b1;
        end
      end else if (m_calc) begin
        m_calc = 1'b0;
        m_rv   = 1'b1;
        m_res  = m_prod;
        m_id   = IDW'(m_owner);
      end else if (m_rv && rsp_ready) begin
        m_rv   = 1'b0;
        m_busy = 1'b0;
        m_rr   = (m_owner + 1) % N;
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int g;
    #2;
    exp_rdy = '0;
    g = grant_of(req_valid, m_rr);
    if (!rst && !m_busy && g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    check("rsp_id", 32'(rsp_id), 32'(m_id));
    check("rsp_result", 32'(rsp_result), 32'(m_res));
    check("busy", 32'(busy), 32'(m_busy));
  end

  initial begin
    int p;
    rsp_ready = 1'b1;
    next();
    next(); req_valid = 4'hF; #2;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    next(); req_valid = '0; rst = 1'b0;

    // single request on port 0
    next(); set_op(0, 12'd12, 12'd11); #2;
    check("t1_ready", 32'(req_ready), 32'h1);
    next(); req_valid[0] = 1'b0;
    next(); #2;
    check("t1_valid", 32'(rsp_valid), 32'd1);
    check("t1_result", 32'(rsp_result), 32'd132);
    check("t1_id", 32'(rsp_id), 32'd0);
    next(); #2;
    check("t1_done", 32'(rsp_valid), 32'd0);

    // max operands on port 2
    next(); set_op(2, 12'hFFF, 12'hFFF); #2;
    check("t2_ready", 32'(req_ready), 32'h4);
    next(); req_valid[2] = 1'b0;
    next(); #2;
    check("t2_result", 32'(rsp_result), 32'h7FE001);
    check("t2_id", 32'(rsp_id), 32'd2);
    next();

    // port 1 alone from rr_ptr=3 wraps, leaving rr_ptr=2
    next(); set_op(1, 12'd1, 12'd1); #2;
    check("wrap_ready", 32'(req_ready), 32'h2);
    next(); req_valid[1] = 1'b0;
    next(); next();

    // ports 3 and 1 from rr_ptr=2, with backpressure on the first response
    next(); rsp_ready = 1'b0; set_op(3, 12'd100, 12'd200); set_op(1, 12'd7, 12'd9); #2;
    check("t5_first", 32'(req_ready), 32'h8);
    next(); req_valid[3] = 1'b0; #2;
    check("t5_calc_ready", 32'(req_ready), 32'h0);
    repeat (5) begin
      next(); #2;
      check("t4_valid", 32'(rsp_valid), 32'd1);
      check("t4_result", 32'(rsp_result), 32'd20000);
      check("t4_id", 32'(rsp_id), 32'd3);
      check("t4_busy", 32'(busy), 32'd1);
      check("t4_ready", 32'(req_ready), 32'h0);
    end
    next(); rsp_ready = 1'b1; #2;
    check("t4_hold", 32'(rsp_valid), 32'd1);
    next(); #2;
    check("t4_idle_valid", 32'(rsp_valid), 32'd0);
    check("t4_idle_busy", 32'(busy), 32'd0);
    check("t5_second", 32'(req_ready), 32'h2);
    next(); req_valid[1] = 1'b0;
    next(); #2;
    check("t5_result", 32'(rsp_result), 32'd63);
    check("t5_id", 32'(rsp_id), 32'd1);
    next();

    // all four valid from reset: grants 0,1,2,3,0
    next(); rst = 1'b1;
    next(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 12'(100 + 37 * i), 12'(3000 + 211 * i));
    for (int n = 0; n < 5; n++) begin
      p = n % N;
      #2;
      check("t3_grant", 32'(req_ready), 32'(1 << p));
      next(); next(); #2;
      check("t3_id", 32'(rsp_id), 32'(p));
      check("t3_result", 32'(rsp_result), 32'(prod(12'(100 + 37 * p), 12'(3000 + 211 * p))));
      next();
    end
    req_valid = '0;

    // reset while an op is in CALC
    next(); set_op(1, 12'd55, 12'd66); #2;
    check("t6_ready", 32'(req_ready), 32'h2);
    next(); req_valid[1] = 1'b0; set_op(2, 12'd1, 12'd2); rst = 1'b1; #1;
    check("t6_rst_valid", 32'(rsp_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ready", 32'(req_ready), 32'h0);
    next(); rst = 1'b0; req_valid = '0;
    repeat (4) begin
      next(); #2;
      check("t6_no_rsp", 32'(rsp_valid), 32'd0);
    end
    next(); set_op(0, 12'd5, 12'd6); set_op(2, 12'd8, 12'd8); #2;
    check("t6_port0", 32'(req_ready), 32'h1);
    next(); req_valid = '0;
    next(); #2;
    check("t6_result", 32'(rsp_result), 32'd30);
    check("t6_id", 32'(rsp_id), 32'd0);
    next();

    // randomized traffic; requesters hold their operands until accepted
    for (int c = 0; c < 3000; c++) begin
      next();
      for (int i = 0; i < N; i++) begin
        if (m_acc[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_a[12*i +: 12] = rnd_op();
          req_b[12*i +: 12] = rnd_op();
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          set_op(i, rnd_op(), rnd_op());
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
    end
    next(); rst = 1'b0;
    next();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
